// File: rtl/present_pkg.sv
// Shared constants, FSM encoding and PRESENT-80 layer functions.
// S-box tables, nibble substitution and bit permutation, forward and inverse.
package present_pkg;

    localparam int ROUNDS = 31;
    localparam int RC_W   = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        KEY   = 3'd2,
        ROUND = 3'd3,
        FINAL = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = SBOX[x[4*i +: 4]];
        return y;
    endfunction

    function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = INV_SBOX[x[4*i +: 4]];
        return y;
    endfunction

    // Bit i moves to (16*i) mod 63; bit 63 stays in place.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[(16 * i) % 63] = x[i];
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[i] = x[(16 * i) % 63];
        y[63] = x[63];
        return y;
    endfunction

endpackage

// File: rtl/present80_iter_core_if.sv
// Controller-to-core bus: operands and mode in, result and completion flags out.
interface present80_iter_core_if;

    logic [63:0] block_i;
    logic [79:0] key;
    logic        encdec;
    logic [63:0] block_o;
    logic        end_key_signal;
    logic        end_enc;
    logic        end_dec;

    modport master (
        output block_i, key, encdec,
        input  block_o, end_key_signal, end_enc, end_dec
    );

    modport slave (
        input  block_i, key, encdec,
        output block_o, end_key_signal, end_enc, end_dec
    );

endinterface

// File: rtl/present_key_update.sv
// Combinational PRESENT-80 key register step; dir=0 forward, dir=1 exact inverse.
module present_key_update
    import present_pkg::*;
(
    input  logic [79:0]     key_in,
    input  logic [RC_W-1:0] rc,
    input  logic            dir,
    output logic [79:0]     key_out
);

    logic [79:0] fwd;
    logic [79:0] inv_pre;

    always_comb begin
        fwd            = {key_in[18:0], key_in[79:19]};
        fwd[79:76]     = SBOX[fwd[79:76]];
        fwd[19:15]     = fwd[19:15] ^ rc;

        inv_pre        = key_in;
        inv_pre[19:15] = inv_pre[19:15] ^ rc;
        inv_pre[79:76] = INV_SBOX[inv_pre[79:76]];
    end

    // Right rotation by 61 undoes the forward left rotation by 61.
    assign key_out = dir ? {inv_pre[60:0], inv_pre[79:61]} : fwd;

endmodule

// File: rtl/present80_iter_core.sv
// Iterative PRESENT-80 core: 31 key-schedule steps, then 31 rounds, one per clock.
// state | meaning
// IDLE  | waiting for reset release; latches operands on the first free edge
// LOAD  | first key-schedule step (rc=1)
// KEY   | remaining key-schedule steps up to rc=31
// ROUND | one cipher round per edge, forward or inverse
// FINAL | whitening with the last round key, result flag raised
// DONE  | result held until reset
module present80_iter_core
    import present_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    present80_iter_core_if.slave bus
);

    localparam logic [RC_W-1:0] RC_FIRST = RC_W'(1);
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(ROUNDS);

    state_t          state;
    state_t          state_nxt;
    logic [RC_W-1:0] rc;
    logic [63:0]     state_reg;
    logic [63:0]     block_o_q;
    logic [79:0]     key_reg;
    logic [79:0]     key_orig;
    logic [79:0]     key_nxt;
    logic [63:0]     rk;
    logic            mode;
    logic            key_dir;
    logic            round_last;
    logic            end_key_q;
    logic            end_enc_q;
    logic            end_dec_q;

    assign rk         = key_reg[79:16];
    assign key_dir    = (state == ROUND) && mode;
    assign round_last = mode ? (rc == RC_FIRST) : (rc == RC_LAST);

    present_key_update u_key_update (
        .key_in  (key_reg),
        .rc      (rc),
        .dir     (key_dir),
        .key_out (key_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      state_nxt = LOAD;
            LOAD, KEY: state_nxt = (rc == RC_LAST) ? ROUND : KEY;
            ROUND:     if (round_last) state_nxt = FINAL;
            FINAL:     state_nxt = DONE;
            DONE:      state_nxt = DONE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rc        <= '0;
            state_reg <= '0;
            key_reg   <= '0;
            key_orig  <= '0;
            mode      <= 1'b0;
            block_o_q <= '0;
            end_key_q <= 1'b0;
            end_enc_q <= 1'b0;
            end_dec_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_reg <= bus.block_i;
                    key_reg   <= bus.key;
                    key_orig  <= bus.key;
                    mode      <= bus.encdec;
                    rc        <= RC_FIRST;
                end
                LOAD, KEY: begin
                    if (rc == RC_LAST) begin
                        end_key_q <= 1'b1;
                        // Encrypt restarts from K1; decrypt starts its rounds from K32.
                        if (mode) begin
                            key_reg <= key_nxt;
                        end else begin
                            key_reg <= key_orig;
                            rc      <= RC_FIRST;
                        end
                    end else begin
                        key_reg <= key_nxt;
                        rc      <= rc + RC_W'(1);
                    end
                end
                ROUND: begin
                    state_reg <= mode ? inv_sbox_layer(inv_p_layer(state_reg ^ rk))
                                      : p_layer(sbox_layer(state_reg ^ rk));
                    key_reg   <= key_nxt;
                    if (!mode && rc != RC_LAST)      rc <= rc + RC_W'(1);
                    else if (mode && rc != RC_FIRST) rc <= rc - RC_W'(1);
                end
                FINAL: begin
                    block_o_q <= state_reg ^ rk;
                    end_enc_q <= !mode;
                    end_dec_q <= mode;
                end
                default: ;
            endcase
        end
    end

    assign bus.block_o        = block_o_q;
    assign bus.end_key_signal = end_key_q;
    assign bus.end_enc        = end_enc_q;
    assign bus.end_dec        = end_dec_q;

endmodule

// File: tb/tb_present80_iter_core.sv
// Bench for present80_iter_core: known-answer table, random ops against a
// round-key-array reference model, mid-flight abort and input-toggle cases.
module tb_present80_iter_core;

    typedef struct packed {
        logic [63:0] blk;
        logic [79:0] key;
        logic        dec;
        logic [63:0] exp;
    } vec_t;

    localparam logic [3:0] SB [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    present80_iter_core_if bus ();

    present80_iter_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic checki(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic logic [3:0] inv_nib(input logic [3:0] v);
        for (int i = 0; i < 16; i++) if (SB[i] == v) return 4'(i);
        return 4'h0;
    endfunction

    function automatic logic [63:0] sub_nibbles(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[4*i +: 4] = inv ? inv_nib(s[4*i +: 4]) : SB[s[4*i +: 4]];
        return o;
    endfunction

    function automatic logic [63:0] perm(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        int          j;
        o = '0;
        for (int i = 0; i < 63; i++) begin
            j = (16 * i) % 63;
            if (inv) o[i] = s[j];
            else     o[j] = s[i];
        end
        o[63] = s[63];
        return o;
    endfunction

    function automatic logic [79:0] ks_next(input logic [79:0] k, input int r);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = SB[t[79:76]];
        t[19:15]   = t[19:15] ^ 5'(r);
        return t;
    endfunction

    function automatic logic [63:0] model_op(input logic [63:0] blk, input logic [79:0] k, input bit dec);
        logic [63:0] rks [1:32];
        logic [79:0] kr;
        logic [63:0] s;
        kr = k;
        for (int r = 1; r <= 32; r++) begin
            rks[r] = kr[79:16];
            if (r < 32) kr = ks_next(kr, r);
        end
        s = blk;
        if (!dec) begin
            for (int r = 1; r <= 31; r++) s = perm(sub_nibbles(s ^ rks[r], 1'b0), 1'b0);
            s = s ^ rks[32];
        end else begin
            s = s ^ rks[32];
            for (int r = 31; r >= 1; r--) s = sub_nibbles(perm(s, 1'b1), 1'b1) ^ rks[r];
        end
        return s;
    endfunction

    // Edge E is the first posedge with rst low; sample n is taken 1 ns after edge E+n.
    task automatic run_op(input string name, input logic [63:0] blk, input logic [79:0] k,
                          input logic dec, input logic [63:0] exp, input bit scramble,
                          input int abort_at, input bit skip_reset);
        int key_edge;
        int res_edge;
        bit both;
        bit early;
        bit aborted;
        if (!skip_reset) begin
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            checki($sformatf("%s reset_flags", name),
                   int'({bus.end_key_signal, bus.end_enc, bus.end_dec}), 0);
            check64($sformatf("%s reset_block_o", name), bus.block_o, 64'h0);
        end
        @(negedge clk);
        rst         = 1'b0;
        bus.block_i = blk;
        bus.key     = k;
        bus.encdec  = dec;
        @(posedge clk);
        key_edge = -1;
        res_edge = -1;
        both     = 1'b0;
        early    = 1'b0;
        aborted  = 1'b0;
        for (int n = 0; n <= 70; n++) begin
            #1;
            if (key_edge < 0 && bus.end_key_signal) key_edge = n;
            if (res_edge < 0 && (bus.end_enc || bus.end_dec)) res_edge = n;
            if (bus.end_enc && bus.end_dec) both = 1'b1;
            if (res_edge < 0 && bus.block_o != 64'h0) early = 1'b1;
            if (scramble) begin
                bus.block_i = {$urandom(), $urandom()};
                bus.key     = {16'($urandom()), $urandom(), $urandom()};
                bus.encdec  = 1'($urandom_range(0, 1));
            end
            if (abort_at > 0 && n == abort_at - 1) begin
                aborted = 1'b1;
                break;
            end
            if (n < 70) @(posedge clk);
        end
        if (aborted) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            checki($sformatf("%s pre_abort_key_edge", name), key_edge, 31);
            checki($sformatf("%s abort_flags", name),
                   int'({bus.end_key_signal, bus.end_enc, bus.end_dec}), 0);
            check64($sformatf("%s abort_block_o", name), bus.block_o, 64'h0);
        end else begin
            checki($sformatf("%s end_key_edge", name), key_edge, 31);
            checki($sformatf("%s result_edge", name), res_edge, 63);
            checki($sformatf("%s flags_exclusive", name), int'(both), 0);
            checki($sformatf("%s block_o_early", name), int'(early), 0);
            checki($sformatf("%s enc_dec_flags", name), int'({bus.end_enc, bus.end_dec}),
                   dec ? 1 : 2);
            check64($sformatf("%s block_o", name), bus.block_o, exp);
        end
    endtask

    initial begin
        vec_t        vecs [8];
        logic [63:0] r_blk;
        logic [79:0] r_key;
        logic        r_dec;

        vecs[0] = '{blk: 64'h0000000000000000, key: 80'h0,                    dec: 1'b0, exp: 64'h5579C1387B228445};
        vecs[1] = '{blk: 64'h0000000000000000, key: 80'hFFFFFFFFFFFFFFFFFFFF, dec: 1'b0, exp: 64'hE72C46C0F5945049};
        vecs[2] = '{blk: 64'hFFFFFFFFFFFFFFFF, key: 80'h0,                    dec: 1'b0, exp: 64'hA112FFC72F68417B};
        vecs[3] = '{blk: 64'hFFFFFFFFFFFFFFFF, key: 80'hFFFFFFFFFFFFFFFFFFFF, dec: 1'b0, exp: 64'h3333DCD3213210D2};
        vecs[4] = '{blk: 64'h5579C1387B228445, key: 80'h0,                    dec: 1'b1, exp: 64'h0000000000000000};
        vecs[5] = '{blk: 64'hE72C46C0F5945049, key: 80'hFFFFFFFFFFFFFFFFFFFF, dec: 1'b1, exp: 64'h0000000000000000};
        vecs[6] = '{blk: 64'hA112FFC72F68417B, key: 80'h0,                    dec: 1'b1, exp: 64'hFFFFFFFFFFFFFFFF};
        vecs[7] = '{blk: 64'h3333DCD3213210D2, key: 80'hFFFFFFFFFFFFFFFFFFFF, dec: 1'b1, exp: 64'hFFFFFFFFFFFFFFFF};

        bus.block_i = '0;
        bus.key     = '0;
        bus.encdec  = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        checki("initial_reset_flags", int'({bus.end_key_signal, bus.end_enc, bus.end_dec}), 0);
        check64("initial_reset_block_o", bus.block_o, 64'h0);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("kat%0d", i), vecs[i].blk, vecs[i].key, vecs[i].dec, vecs[i].exp,
                   1'b0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            r_blk = {$urandom(), $urandom()};
            r_key = {16'($urandom()), $urandom(), $urandom()};
            r_dec = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), r_blk, r_key, r_dec, model_op(r_blk, r_key, r_dec),
                   1'($urandom_range(0, 1)), 0, 1'b0);
        end

        r_blk = {$urandom(), $urandom()};
        r_key = {16'($urandom()), $urandom(), $urandom()};
        run_op("abort_enc", r_blk, r_key, 1'b0, 64'h0, 1'b0, 40, 1'b0);
        run_op("after_abort", 64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF, 1'b0,
               64'h3333DCD3213210D2, 1'b0, 0, 1'b1);

        run_op("toggle_enc", 64'h0, 80'h0, 1'b0, 64'h5579C1387B228445, 1'b1, 0, 1'b0);
        run_op("toggle_dec", 64'hA112FFC72F68417B, 80'h0, 1'b1, 64'hFFFFFFFFFFFFFFFF,
               1'b1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
